gpio_mmio_bank: RTL and testbench

- Parametrised memory-mapped GPIO peripheral; successor to the fixed 8-bit LED/UART register bytes in the SoC top level.
- Sits on the CPU data bus behind the top-level GPIO decode (addr[31:28]==4'h1).
- Provides NCH ports of WIDTH bits, each with:
  - output, direction and atomic set/clear/toggle registers;
  - a synchronised input register;
  - rising-edge interrupt logic.
- Registered read data, one-cycle latency, matching the CPU's memory read timing.

---
 rtl/gpio_bus_if.sv | 13 +
 rtl/gpio_mmio_bank.sv | 160 ++++++++++++++++
 tb/tb_gpio_mmio_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_if.sv
// CPU data-bus slice seen by the GPIO bank: region select, byte address,
// byte-lane write strobes, read strobe and registered read data.
interface gpio_bus_if;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rstrb;
  logic [31:0] rdata;

  modport master (output sel, addr, wdata, wstrb, rstrb, input rdata);
  modport slave  (input sel, addr, wdata, wstrb, rstrb, output rdata);
endinterface

// File: rtl/gpio_mmio_bank.sv
// Memory-mapped GPIO bank: NCH ports of WIDTH bits with OUT/SET/CLR/TGL/DIR/IN.
// Define GPIO_MMIO_IRQ_EN to add IE/IP registers, rising-edge detect and irq.
module gpio_mmio_bank #(
  parameter int NCH         = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_bus_if.slave            bus,
  input  logic [NCH*WIDTH-1:0] gpio_in,
  output logic [NCH*WIDTH-1:0] gpio_out,
  output logic [NCH*WIDTH-1:0] gpio_oe,
  output logic                 irq
);

  localparam int NW = NCH * WIDTH;

  typedef enum logic [2:0] {
    R_OUT = 3'd0,
    R_SET = 3'd1,
    R_CLR = 3'd2,
    R_TGL = 3'd3,
    R_DIR = 3'd4,
    R_IN  = 3'd5,
    R_IE  = 3'd6,
    R_IP  = 3'd7
  } reg_e;

  logic [3:0]       idx;
  reg_e             rsel;
  logic             wr;
  logic             rd;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] lm;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q [NCH];
  logic [WIDTH-1:0] dir_q [NCH];
  logic [NW-1:0]    sync_q [SYNC_STAGES];
  logic [NW-1:0]    synced;
  logic [31:0]      rd_val;
  logic [31:0]      rdata_q;
  logic             unused_bits;

  assign idx       = bus.addr[8:5];
  assign rsel      = reg_e'(bus.addr[4:2]);
  assign wr        = bus.sel & (|bus.wstrb);
  assign rd        = bus.sel & bus.rstrb;
  assign lane_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}},
                      {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign lm        = lane_mask[WIDTH-1:0];
  // Write data with inactive byte lanes forced to 0; bits above WIDTH dropped.
  assign wd        = bus.wdata[WIDTH-1:0] & lm;
  assign synced    = sync_q[SYNC_STAGES-1];
  assign bus.rdata = rdata_q;

  // Upper address bits are decoded at the top level; the low two are byte offset.
  assign unused_bits = ^{bus.addr[31:9], bus.addr[1:0], bus.wdata, lane_mask};

  for (genvar p = 0; p < NCH; p++) begin : g_pad
    assign gpio_out[p*WIDTH +: WIDTH] = out_q[p];
    assign gpio_oe[p*WIDTH +: WIDTH]  = dir_q[p];
  end

`ifdef GPIO_MMIO_IRQ_EN
  logic [NW-1:0]    prev_q;
  logic [NW-1:0]    rise;
  logic [WIDTH-1:0] ie_q [NCH];
  logic [WIDTH-1:0] ip_q [NCH];
  logic             pend;
  logic             irq_q;

  assign rise = synced & ~prev_q;
  assign irq  = irq_q;

  always_comb begin
    pend = 1'b0;
    for (int p = 0; p < NCH; p++) begin
      pend = pend | (|(ip_q[p] & ie_q[p]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      irq_q  <= 1'b0;
      for (int p = 0; p < NCH; p++) begin
        ie_q[p] <= '0;
        ip_q[p] <= '0;
      end
    end else begin
      prev_q <= synced;
      irq_q  <= pend;
      for (int p = 0; p < NCH; p++) begin
        if (wr && idx == 4'(p) && rsel == R_IE) begin
          ie_q[p] <= (ie_q[p] & ~lm) | wd;
        end
        // A new rise on a bit wins over a W1C of the same bit.
        ip_q[p] <= (ip_q[p] & ~((wr && idx == 4'(p) && rsel == R_IP) ? wd : '0))
                   | rise[p*WIDTH +: WIDTH];
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NCH; p++) begin
      if (idx == 4'(p)) begin
        case (rsel)
          R_OUT: rd_val[WIDTH-1:0] = out_q[p];
          R_DIR: rd_val[WIDTH-1:0] = dir_q[p];
          R_IN:  rd_val[WIDTH-1:0] = synced[p*WIDTH +: WIDTH];
`ifdef GPIO_MMIO_IRQ_EN
          R_IE:  rd_val[WIDTH-1:0] = ie_q[p];
          R_IP:  rd_val[WIDTH-1:0] = ip_q[p];
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int p = 0; p < NCH; p++) begin
        out_q[p] <= '0;
        dir_q[p] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      // rd_val is built from pre-edge state, so a read+write returns the old value.
      if (rd) begin
        rdata_q <= rd_val;
      end
      for (int p = 0; p < NCH; p++) begin
        if (wr && idx == 4'(p)) begin
          case (rsel)
            R_OUT:   out_q[p] <= (out_q[p] & ~lm) | wd;
            R_SET:   out_q[p] <= out_q[p] | wd;
            R_CLR:   out_q[p] <= out_q[p] & ~wd;
            R_TGL:   out_q[p] <= out_q[p] ^ wd;
            R_DIR:   dir_q[p] <= (dir_q[p] & ~lm) | wd;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// Scoreboard bench for gpio_mmio_bank (NCH=2, WIDTH=8, SYNC_STAGES=2), directed
// sequence followed by random bus traffic; follows GPIO_MMIO_IRQ_EN like the DUT.
module tb_gpio_mmio_bank;

  localparam int NCH = 2;
  localparam int S   = 2;
`ifdef GPIO_MMIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  gpio_bus_if bus ();

  gpio_mmio_bank #(.NCH(2), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: register contents per port plus a history of pad samples.
  logic [7:0]  out_m [NCH];
  logic [7:0]  dir_m [NCH];
  logic [7:0]  ie_m  [NCH];
  logic [7:0]  ip_m  [NCH];
  logic        irq_m;
  logic [15:0] hist [$];
  logic [15:0] pin_drv;

  logic [31:0] exp_rd  [$];
  logic [32:0] exp_out [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, advance the model across the next posedge.
  task automatic op(input logic s, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] ws, input logic rs, input logic r);
    logic [31:0] lmk;
    logic [31:0] dm;
    logic [31:0] rv;
    logic [15:0] syn;
    logic [15:0] prv;
    logic [7:0]  rise;
    logic [7:0]  w1c;
    logic        pend;
    logic        wr;
    int          p;
    int          rg;
    bus.sel   = s;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = ws;
    bus.rstrb = rs;
    rst       = r;
    gpio_in   = pin_drv;
    for (int k = 0; k < 4; k++) lmk[k*8 +: 8] = ws[k] ? 8'hFF : 8'h00;
    dm  = d & lmk;
    p   = int'(a[8:5]);
    rg  = int'(a[4:2]);
    syn = hist[S-1];
    prv = hist[S];
    rv  = 32'h0;
    if (p < NCH) begin
      case (rg)
        0: rv = {24'h0, out_m[p]};
        4: rv = {24'h0, dir_m[p]};
        5: rv = {24'h0, syn[p*8 +: 8]};
        6: if (IRQ) rv = {24'h0, ie_m[p]};
        7: if (IRQ) rv = {24'h0, ip_m[p]};
        default: rv = 32'h0;
      endcase
    end
    if (r || (s && rs)) exp_rd.push_back(r ? 32'h0 : rv);
    if (r) begin
      for (int q = 0; q < NCH; q++) begin
        out_m[q] = 8'h0; dir_m[q] = 8'h0; ie_m[q] = 8'h0; ip_m[q] = 8'h0;
      end
      irq_m = 1'b0;
      hist = {};
      for (int k = 0; k <= S; k++) hist.push_back(16'h0);
    end else begin
      pend = 1'b0;
      for (int q = 0; q < NCH; q++) pend = pend | (|(ip_m[q] & ie_m[q]));
      irq_m = IRQ && pend;
      wr = s && (ws != 4'h0) && (p < NCH);
      if (wr) begin
        case (rg)
          0: out_m[p] = (out_m[p] & ~lmk[7:0]) | dm[7:0];
          1: out_m[p] = out_m[p] | dm[7:0];
          2: out_m[p] = out_m[p] & ~dm[7:0];
          3: out_m[p] = out_m[p] ^ dm[7:0];
          4: dir_m[p] = (dir_m[p] & ~lmk[7:0]) | dm[7:0];
          6: if (IRQ) ie_m[p] = (ie_m[p] & ~lmk[7:0]) | dm[7:0];
          default: ;
        endcase
      end
      if (IRQ) begin
        for (int q = 0; q < NCH; q++) begin
          rise    = syn[q*8 +: 8] & ~prv[q*8 +: 8];
          w1c     = (wr && p == q && rg == 7) ? dm[7:0] : 8'h0;
          ip_m[q] = (ip_m[q] & ~w1c) | rise;
        end
      end
      hist.push_front(pin_drv);
      void'(hist.pop_back());
    end
    exp_out.push_back({out_m[1], out_m[0], dir_m[1], dir_m[0], irq_m});
    @(negedge clk);
  endtask

  task automatic idle();
    op(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every edge has an expected output state; reads (and resets) also
  // present a new rdata one edge later.
  logic        rd_ev;
  logic [32:0] e_out;
  logic [31:0] e_rd;
  always begin
    @(posedge clk);
    rd_ev = rst || (bus.sel && bus.rstrb);
    #1;
    if (exp_out.size() > 0) begin
      e_out = exp_out.pop_front();
      chk("gpio_out", {16'h0, gpio_out}, {16'h0, e_out[32:17]});
      chk("gpio_oe",  {16'h0, gpio_oe},  {16'h0, e_out[16:1]});
      chk("irq",      {31'h0, irq},      {31'h0, e_out[0]});
    end
    if (rd_ev) begin
      if (exp_rd.size() == 0) begin
        chk("rdata_unexpected", 32'h1, 32'h0);
      end else begin
        e_rd = exp_rd.pop_front();
        chk("rdata", bus.rdata, e_rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] a;
    pin_drv = 16'h0;
    // Reset and read back
    op(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    op(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    chk("rst_gpio_oe",  {16'h0, gpio_oe},  32'h0);
    chk("rst_irq",      {31'h0, irq},      32'h0);
    op(1'b1, 32'h00, 32'h0, 4'h0, 1'b1, 1'b0);
    op(1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    op(1'b1, 32'h18, 32'h0, 4'h0, 1'b1, 1'b0);
    op(1'b1, 32'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("rst_read_ip", bus.rdata, 32'h0);

    // OUT / SET / CLR / TGL
    op(1'b1, 32'h00, 32'h0000_00A5, 4'b0001, 1'b0, 1'b0);
    chk("out_a5", {24'h0, gpio_out[7:0]}, 32'hA5);
    op(1'b1, 32'h04, 32'h0000_000A, 4'b0001, 1'b0, 1'b0);
    chk("set_af", {24'h0, gpio_out[7:0]}, 32'hAF);
    op(1'b1, 32'h08, 32'h0000_0081, 4'b0001, 1'b0, 1'b0);
    chk("clr_2e", {24'h0, gpio_out[7:0]}, 32'h2E);
    op(1'b1, 32'h0C, 32'h0000_00FF, 4'b0001, 1'b0, 1'b0);
    chk("tgl_d1", {24'h0, gpio_out[7:0]}, 32'hD1);
    op(1'b1, 32'h00, 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
    chk("nostrb_d1", {24'h0, gpio_out[7:0]}, 32'hD1);
    op(1'b1, 32'h04, 32'h0000_FF00, 4'b0010, 1'b0, 1'b0);
    chk("lane1_ignored", {24'h0, gpio_out[7:0]}, 32'hD1);

    // Port decode and read/write overlap
    op(1'b1, 32'h30, 32'h0000_003C, 4'b1111, 1'b0, 1'b0);
    chk("dir_p1", {24'h0, gpio_oe[15:8]}, 32'h3C);
    op(1'b1, 32'h50, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0);
    chk("bad_port_wr", {16'h0, gpio_oe}, 32'h3C00);
    op(1'b1, 32'h50, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("bad_port_rd", bus.rdata, 32'h0);
    op(1'b0, 32'h00, 32'h0000_0055, 4'b0001, 1'b1, 1'b0);
    chk("sel0_hold", bus.rdata, 32'h0);
    op(1'b1, 32'h00, 32'h0000_0012, 4'b0001, 1'b1, 1'b0);
    chk("rw_old_value", bus.rdata, 32'hD1);
    chk("rw_new_out", {24'h0, gpio_out[7:0]}, 32'h12);

    // Input synchroniser and edge interrupt on port0 bit0
    op(1'b1, 32'h18, 32'h0000_0001, 4'b0001, 1'b0, 1'b0);
    pin_drv = 16'h0001;
    op(1'b1, 32'h14, 32'h0, 4'h0, 1'b1, 1'b0);
    op(1'b1, 32'h14, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("in_early", bus.rdata, 32'h0);
    op(1'b1, 32'h14, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("in_after_2", bus.rdata, 32'h1);
    op(1'b1, 32'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
`ifdef GPIO_MMIO_IRQ_EN
    chk("ip_set", bus.rdata, 32'h1);
    chk("irq_set", {31'h0, irq}, 32'h1);
`else
    chk("ip_absent", bus.rdata, 32'h0);
    chk("irq_absent", {31'h0, irq}, 32'h0);
`endif

    // W1C without an edge, then W1C racing a new rise
    op(1'b1, 32'h1C, 32'h0000_0001, 4'b0001, 1'b0, 1'b0);
    op(1'b1, 32'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("w1c_ip", bus.rdata, 32'h0);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    pin_drv = 16'h0000;
    idle(); idle(); idle();
    pin_drv = 16'h0001;
    idle(); idle();
    op(1'b1, 32'h1C, 32'h0000_0001, 4'b0001, 1'b0, 1'b0);
    op(1'b1, 32'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
`ifdef GPIO_MMIO_IRQ_EN
    chk("race_ip", bus.rdata, 32'h1);
`else
    chk("race_ip_absent", bus.rdata, 32'h0);
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) pin_drv = 16'($urandom);
      rnd = $urandom;
      a = {rnd[31:9], 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rnd[1:0]};
      op(($urandom_range(0, 7) != 0), a, $urandom,
         ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom),
         1'($urandom), ($urandom_range(0, 99) == 0));
    end
    idle(); idle();
    chk("rd_queue_drain", 32'(exp_rd.size()), 32'h0);
    chk("out_queue_drain", 32'(exp_out.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
